// File: rtl/cm811_ram_check_unit.sv
// cm811_ram_check_unit
// Per-RAM march self-test responder for the CM811 PFPGA init path.
// One check_en pulse starts the test:
//   1. Write P to every address.
//   2. For each address, read and verify P, then write ~P.
//   3. For each address, read and verify ~P.
// The outcome is a one-cycle check_done or check_error pulse.
// The first mismatch is recorded in err_addr/err_data.
// Optional build macro CM811_RAM_CHECK_CLEAR_EN: after a passing test the RAM
// is cleared to zero (one address per cycle) before check_done is pulsed.
module cm811_ram_check_unit #(
   parameter int unsigned        ADDR_W  = 10,
   parameter int unsigned        DATA_W  = 16,
   parameter int unsigned        RD_LAT  = 1,
   parameter logic [DATA_W-1:0]  PATTERN = 16'h5A5A
) (
   input  logic              sys_clk,
   input  logic              glbl_rst_n,
   input  logic              check_en,
   output logic              check_done,
   output logic              check_error,
   output logic              check_busy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [ADDR_W-1:0] err_addr,
   output logic [DATA_W-1:0] err_data
);

   localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;
   localparam int unsigned       WAIT_W      = 2;
   // Extra cycles spent between presenting a read address and comparing.
   localparam logic [WAIT_W-1:0] WAIT_CYCLES = WAIT_W'(RD_LAT - 1);
   localparam logic [DATA_W-1:0] PATTERN_N   = ~PATTERN;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_P,
      S_RD_P,
      S_WAIT_P,
      S_CMP_P,
      S_RD_N,
      S_WAIT_N,
      S_CMP_N,
`ifdef CM811_RAM_CHECK_CLEAR_EN
      S_CLR,
`endif
      S_FIN
   } state_e;

   state_e              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [WAIT_W-1:0]   wait_q;
   logic                we_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                done_q;
   logic                error_q;
   logic                busy_q;
   logic [ADDR_W-1:0]   err_addr_q;
   logic [DATA_W-1:0]   err_data_q;

   // Test sequencer: state, address counter and every registered output.
   // NOTE: all state here uses non-blocking assignments so every register
   // sees the pre-edge values of the others, regardless of statement order.
   always_ff @(posedge sys_clk) begin
      if (!glbl_rst_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         wait_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         busy_q     <= 1'b0;
         err_addr_q <= '0;
         err_data_q <= '0;
      end else begin
         // Result flags are single-cycle; they are raised only on the
         // terminal transitions below.
         done_q  <= 1'b0;
         error_q <= 1'b0;

         unique case (state_q)
            S_IDLE: begin
               if (check_en) begin
                  err_addr_q <= '0;
                  err_data_q <= '0;
                  addr_q     <= '0;
                  we_q       <= 1'b1;
                  wdata_q    <= PATTERN;
                  busy_q     <= 1'b1;
                  state_q    <= S_WR_P;
               end
            end

            S_WR_P: begin
               if (addr_q == LAST_ADDR) begin
                  addr_q  <= '0;
                  we_q    <= 1'b0;
                  state_q <= S_RD_P;
               end else begin
                  addr_q <= addr_q + ADDR_W'(1);
               end
            end

            // The ~P write-back must land in the compare cycle, and outputs
            // are registered, so ram_we/ram_wdata are raised on entry to
            // CMP_P. On a mismatch the stray write is harmless because the
            // test is abandoned at that point.
            S_RD_P: begin
               if (WAIT_CYCLES == '0) begin
                  we_q    <= 1'b1;
                  wdata_q <= PATTERN_N;
                  state_q <= S_CMP_P;
               end else begin
                  wait_q  <= WAIT_CYCLES - WAIT_W'(1);
                  state_q <= S_WAIT_P;
               end
            end

            S_WAIT_P: begin
               if (wait_q == '0) begin
                  we_q    <= 1'b1;
                  wdata_q <= PATTERN_N;
                  state_q <= S_CMP_P;
               end else begin
                  wait_q <= wait_q - WAIT_W'(1);
               end
            end

            S_CMP_P: begin
               we_q <= 1'b0;
               if (ram_rdata != PATTERN) begin
                  err_addr_q <= addr_q;
                  err_data_q <= ram_rdata;
                  error_q    <= 1'b1;
                  busy_q     <= 1'b0;
                  addr_q     <= '0;
                  state_q    <= S_IDLE;
               end else if (addr_q == LAST_ADDR) begin
                  addr_q  <= '0;
                  state_q <= S_RD_N;
               end else begin
                  addr_q  <= addr_q + ADDR_W'(1);
                  state_q <= S_RD_P;
               end
            end

            S_RD_N: begin
               if (WAIT_CYCLES == '0) begin
                  state_q <= S_CMP_N;
               end else begin
                  wait_q  <= WAIT_CYCLES - WAIT_W'(1);
                  state_q <= S_WAIT_N;
               end
            end

            S_WAIT_N: begin
               if (wait_q == '0) begin
                  state_q <= S_CMP_N;
               end else begin
                  wait_q <= wait_q - WAIT_W'(1);
               end
            end

            S_CMP_N: begin
               if (ram_rdata != PATTERN_N) begin
                  err_addr_q <= addr_q;
                  err_data_q <= ram_rdata;
                  error_q    <= 1'b1;
                  busy_q     <= 1'b0;
                  addr_q     <= '0;
                  state_q    <= S_IDLE;
               end else if (addr_q == LAST_ADDR) begin
                  addr_q  <= '0;
`ifdef CM811_RAM_CHECK_CLEAR_EN
                  we_q    <= 1'b1;
                  wdata_q <= '0;
                  state_q <= S_CLR;
`else
                  state_q <= S_FIN;
`endif
               end else begin
                  addr_q  <= addr_q + ADDR_W'(1);
                  state_q <= S_RD_N;
               end
            end

`ifdef CM811_RAM_CHECK_CLEAR_EN
            S_CLR: begin
               if (addr_q == LAST_ADDR) begin
                  addr_q  <= '0;
                  we_q    <= 1'b0;
                  state_q <= S_FIN;
               end else begin
                  addr_q <= addr_q + ADDR_W'(1);
               end
            end
`endif

            S_FIN: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end

            default: begin
               we_q    <= 1'b0;
               busy_q  <= 1'b0;
               addr_q  <= '0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign check_done  = done_q;
   assign check_error = error_q;
   assign check_busy  = busy_q;
   assign ram_addr    = addr_q;
   assign ram_we      = we_q;
   assign ram_wdata   = wdata_q;
   assign err_addr    = err_addr_q;
   assign err_data    = err_data_q;

endmodule

// File: tb/tb_cm811_ram_check_unit.sv
// Bench for cm811_ram_check_unit.
// Two instances (RD_LAT=1 and RD_LAT=3) each drive their own RAM model.
// Each RAM model has an optional stuck-at-1 read fault.
// A behavioural model derives every expected output from the cycle count
// since acceptance. A per-instance compare process checks the outputs against
// that model on every cycle.
module tb_cm811_ram_check_unit;

   localparam int AW = 4;
   localparam int DW = 16;
   localparam int N  = 1 << AW;
   localparam logic [DW-1:0] P = 16'h5A5A;
`ifdef CM811_RAM_CHECK_CLEAR_EN
   localparam int            CLRN       = N;
   localparam logic [DW-1:0] FINAL_WORD = 16'h0000;
   localparam int            LAT_L1     = 97;
   localparam int            LAT_L3     = 161;
`else
   localparam int            CLRN       = 0;
   localparam logic [DW-1:0] FINAL_WORD = 16'hA5A5;
   localparam int            LAT_L1     = 81;
   localparam int            LAT_L3     = 145;
`endif
   localparam int IDLE_LIMIT = 1000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          check_en;
   logic          fault_en;
   logic [AW-1:0] fault_addr;
   logic [DW-1:0] fault_mask;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   task automatic check(input int inst, input string name,
                        input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL inst%0d %s: got 0x%0h, required 0x%0h", inst, name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int L   = (g == 0) ? 1 : 3;
      localparam int PER = L + 1;

      logic          done, error, busy, we;
      logic [AW-1:0] addr, ea;
      logic [DW-1:0] wdata, rdata, ed, rd_now;
      logic [DW-1:0] mem  [N];
      logic [DW-1:0] pipe [L];

      cm811_ram_check_unit #(
         .ADDR_W(AW), .DATA_W(DW), .RD_LAT(L), .PATTERN(P)
      ) dut (
         .sys_clk(clk), .glbl_rst_n(rst_n), .check_en(check_en),
         .check_done(done), .check_error(error), .check_busy(busy),
         .ram_addr(addr), .ram_we(we), .ram_wdata(wdata), .ram_rdata(rdata),
         .err_addr(ea), .err_data(ed)
      );

      // Single-port RAM with an L-cycle read pipeline and optional stuck-at-1 bits on read
      assign rd_now = mem[addr] | ((fault_en && addr == fault_addr) ? fault_mask : '0);
      assign rdata  = pipe[L-1];

      always @(posedge clk) begin
         if (we) mem[addr] <= wdata;
         pipe[0] <= rd_now;
         for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end

      // Behavioural model (updated on posedge) and output comparison (on negedge)
      int            k = -1;
      int            end_k = 0;
      int            kc;
      bit            fail;
      bit            in_rst = 1'b1;
      bit            busy_s = 1'b0;
      logic [AW-1:0] fa, x_ea;
      logic [DW-1:0] fd, x_ed, want, got;
      int            cyc = 0, t0 = 0, last_lat = 0, n_done = 0, n_err = 0;
      int            j, pass, r, a, o, exp_addr;
      bit            exp_we, addr_valid;
      logic [DW-1:0] exp_wd;

      always begin
         @(posedge clk);
         cyc++;
         if (rst_n && check_en && !busy_s) t0 = cyc;
         if (!rst_n) begin
            in_rst = 1'b1;
            k      = -1;
            x_ea   = '0;
            x_ed   = '0;
         end else begin
            in_rst = 1'b0;
            if (k < 0 || k == end_k) begin
               if (check_en) begin
                  k    = 0;
                  x_ea = '0;
                  x_ed = '0;
                  fail = 1'b0;
                  kc   = 0;
                  fa   = '0;
                  fd   = '0;
                  for (int ps = 0; ps < 2; ps++) begin
                     for (int aa = 0; aa < N; aa++) begin
                        want = (ps == 0) ? P : ~P;
                        got  = want | ((fault_en && aa == int'(fault_addr)) ? fault_mask : '0);
                        if (!fail && got != want) begin
                           fail = 1'b1;
                           fa   = AW'(aa);
                           fd   = got;
                           kc   = N + ps * N * PER + aa * PER + PER - 1;
                        end
                     end
                  end
                  end_k = fail ? kc + 1 : N + 2 * N * PER + CLRN + 1;
               end else begin
                  k = -1;
               end
            end else begin
               k++;
               if (k == end_k && fail) begin
                  x_ea = fa;
                  x_ed = fd;
               end
            end
         end

         @(negedge clk);
         busy_s = busy;
         if (done)  begin n_done++; last_lat = cyc - t0; end
         if (error) n_err++;
         if (in_rst) begin
            check(g, "reset_outputs", 64'({done, error, busy, we, addr, wdata, ea, ed}), 64'(0));
         end else begin
            check(g, "err_addr", 64'(ea), 64'(x_ea));
            check(g, "err_data", 64'(ed), 64'(x_ed));
            if (k < 0) begin
               check(g, "idle_flags", 64'({done, error, busy, we}), 64'(0));
            end else if (k == end_k) begin
               check(g, "result_flags", 64'({done, error, busy, we}),
                     64'({!fail, fail, 2'b00}));
            end else begin
               addr_valid = 1'b1;
               exp_addr   = 0;
               exp_we     = 1'b0;
               exp_wd     = '0;
               if (k < N) begin
                  exp_addr = k;
                  exp_we   = 1'b1;
                  exp_wd   = P;
               end else if (k - N < 2 * N * PER) begin
                  j        = k - N;
                  pass     = j / (N * PER);
                  r        = j % (N * PER);
                  a        = r / PER;
                  o        = r % PER;
                  exp_addr = a;
                  exp_we   = (o == PER - 1) && (pass == 0);
                  exp_wd   = ~P;
               end else if (k - N - 2 * N * PER < CLRN) begin
                  exp_addr = k - N - 2 * N * PER;
                  exp_we   = 1'b1;
                  exp_wd   = '0;
               end else begin
                  addr_valid = 1'b0;
               end
               check(g, "busy_flags", 64'({done, error, busy}), 64'(3'b001));
               check(g, "ram_we", 64'(we), 64'(exp_we));
               if (addr_valid) check(g, "ram_addr", 64'(addr), 64'(exp_addr));
               if (exp_we)     check(g, "ram_wdata", 64'(wdata), 64'(exp_wd));
            end
         end
      end
   end

   task automatic pulse();
      @(negedge clk) check_en = 1'b1;
      @(negedge clk) check_en = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      repeat (2) @(negedge clk);
      while ((g_inst[0].busy || g_inst[1].busy) && n < IDLE_LIMIT) begin
         @(negedge clk);
         n++;
      end
      check(0, "wait_idle_timeout", 64'(n < IDLE_LIMIT), 64'(1));
      @(negedge clk);
   endtask

   task automatic check_mem(input logic [DW-1:0] word);
      for (int i = 0; i < N; i++) begin
         check(0, "mem_final", 64'(g_inst[0].mem[i]), 64'(word));
         check(1, "mem_final", 64'(g_inst[1].mem[i]), 64'(word));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, d1, e0, e1, n;
      rst_n = 1'b0; check_en = 1'b0;
      fault_en = 1'b0; fault_addr = '0; fault_mask = '0;
      repeat (3) @(negedge clk);
      check(0, "reset_busy_done_err", 64'({g_inst[0].busy, g_inst[0].done, g_inst[0].error}), 64'(0));
      rst_n = 1'b1;

      // Passing run: fixed latency and final RAM contents on both instances
      pulse();
      wait_idle();
      check(0, "done_latency", 64'(g_inst[0].last_lat), 64'(LAT_L1));
      check(1, "done_latency", 64'(g_inst[1].last_lat), 64'(LAT_L3));
      check_mem(FINAL_WORD);

      // Back-to-back: new request the cycle after check_done on the RD_LAT=1 instance
      d0 = g_inst[0].n_done;
      pulse();
      n = 0;
      while (!g_inst[0].done && n < IDLE_LIMIT) begin @(negedge clk); n++; end
      check(0, "done_wait_timeout", 64'(n < IDLE_LIMIT), 64'(1));
      @(negedge clk) check_en = 1'b1;
      @(negedge clk) check_en = 1'b0;
      wait_idle();
      check(0, "b2b_done_count", 64'(g_inst[0].n_done - d0), 64'(2));
      check(0, "b2b_latency", 64'(g_inst[0].last_lat), 64'(LAT_L1));
      check(0, "b2b_err_regs", 64'({g_inst[0].ea, g_inst[0].ed}), 64'(0));

      // check_en repeated mid-test is ignored
      d0 = g_inst[0].n_done; d1 = g_inst[1].n_done;
      pulse();
      repeat (19) @(negedge clk);
      check_en = 1'b1;
      @(negedge clk) check_en = 1'b0;
      wait_idle();
      check(0, "retrigger_done_count", 64'(g_inst[0].n_done - d0), 64'(1));
      check(1, "retrigger_done_count", 64'(g_inst[1].n_done - d1), 64'(1));
      check(0, "retrigger_latency", 64'(g_inst[0].last_lat), 64'(LAT_L1));

      // Address 9 bit 3 stuck at 1: passes P, fails ~P with A5AD
      d0 = g_inst[0].n_done; d1 = g_inst[1].n_done;
      e0 = g_inst[0].n_err;  e1 = g_inst[1].n_err;
      fault_en = 1'b1; fault_addr = 4'd9; fault_mask = 16'h0008;
      pulse();
      wait_idle();
      check(0, "stuck_err_addr", 64'(g_inst[0].ea), 64'(9));
      check(0, "stuck_err_data", 64'(g_inst[0].ed), 64'(16'hA5AD));
      check(1, "stuck_err_addr", 64'(g_inst[1].ea), 64'(9));
      check(1, "stuck_err_data", 64'(g_inst[1].ed), 64'(16'hA5AD));
      check(0, "stuck_counts", 64'({g_inst[0].n_err - e0, g_inst[0].n_done - d0}), 64'({32'd1, 32'd0}));
      check(1, "stuck_counts", 64'({g_inst[1].n_err - e1, g_inst[1].n_done - d1}), 64'({32'd1, 32'd0}));
      fault_en = 1'b0;

      // One-cycle reset at cycle 40 aborts the test silently
      d0 = g_inst[0].n_done; e0 = g_inst[0].n_err;
      pulse();
      repeat (39) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check(0, "midreset_outputs", 64'({g_inst[0].busy, g_inst[0].we, g_inst[0].addr, g_inst[0].ea}), 64'(0));
      check(1, "midreset_outputs", 64'({g_inst[1].busy, g_inst[1].we, g_inst[1].addr, g_inst[1].ea}), 64'(0));
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check(0, "midreset_no_pulse", 64'((g_inst[0].n_done - d0) + (g_inst[0].n_err - e0)), 64'(0));
      pulse();
      wait_idle();
      check(0, "after_reset_done", 64'(g_inst[0].n_done - d0), 64'(1));
      check(0, "after_reset_latency", 64'(g_inst[0].last_lat), 64'(LAT_L1));

      // Randomized faults, gaps and spurious retriggers
      for (int it = 0; it < 10; it++) begin
         fault_en   = ($urandom_range(0, 2) != 0);
         fault_addr = AW'($urandom_range(0, N - 1));
         fault_mask = DW'(1) << $urandom_range(0, DW - 1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         pulse();
         if ($urandom_range(0, 1) != 0) begin
            repeat ($urandom_range(1, 60)) @(negedge clk);
            pulse();
         end
         wait_idle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
